// File: rtl/diff_pkg.sv
// Shared constants and typedefs for the pulse-width line transmitter and receiver.
package diff_pkg;

  localparam int unsigned WORD_W = 26;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_LOW,
    HIGH,
    BIT_LOW,
    DRAIN
  } rx_state_t;

  typedef enum logic [1:0] {
    SYM_ZERO,
    SYM_SYNC,
    SYM_ONE
  } symbol_t;

endpackage

// File: rtl/diff_rx_if.sv
// Line input and decoded-word outputs of the pulse-width receiver.
interface diff_rx_if;
  import diff_pkg::*;

  logic              data_in;
  logic [WORD_W-1:0] data_out;
  logic              valid_out;
  logic              error_out;

  modport master (output data_in, input data_out, input valid_out, input error_out);
  modport slave  (input data_in, output data_out, output valid_out, output error_out);

endinterface

// File: rtl/diff_rx_line_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset level is selectable.
module line_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/diff_rx.sv
// Pulse-width line receiver: measures low pulses, classifies ZERO/SYNC/ONE,
// reassembles a framed word and reports a one-cycle valid or error strobe.
module diff_rx
  import diff_pkg::*;
#(
  parameter int unsigned DATA_PERIOD  = 20,
  parameter int unsigned ZERO_MAX     = 7,
  parameter int unsigned ONE_MIN      = 13,
  parameter int unsigned HIGH_TIMEOUT = 25
) (
  input logic       clk_in,
  input logic       rst_n_in,
  diff_rx_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(HIGH_TIMEOUT + 2);
  localparam int unsigned BIT_W = $clog2(WORD_W + 1);

  logic              line_s;
  logic              line_q;
  logic              fall;
  logic              rise;
  logic [CNT_W-1:0]  low_cnt;
  logic [CNT_W-1:0]  hi_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] shreg;
  symbol_t           sym;
  rx_state_t         state;
  logic              done_q;
  logic              err_q;

  line_sync #(.RST_VAL(1'b1)) u_line_sync (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .d        (bus.data_in),
    .q        (line_s)
  );

  assign fall = line_q & ~line_s;
  assign rise = ~line_q & line_s;

  // Edge register and pulse-width counters, both saturating.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      line_q  <= 1'b1;
      low_cnt <= '0;
      hi_cnt  <= '0;
    end else begin
      line_q <= line_s;
      if (fall)
        low_cnt <= CNT_W'(1);
      else if (!line_s && (low_cnt < CNT_W'(DATA_PERIOD + 1)))
        low_cnt <= low_cnt + CNT_W'(1);
      if (rise)
        hi_cnt <= CNT_W'(1);
      else if (line_s && (hi_cnt < CNT_W'(HIGH_TIMEOUT + 1)))
        hi_cnt <= hi_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    sym = SYM_SYNC;
    if (low_cnt <= CNT_W'(ZERO_MAX))
      sym = SYM_ZERO;
    else if (low_cnt >= CNT_W'(ONE_MIN))
      sym = SYM_ONE;
  end

  // Frame FSM; done_q/err_q feed the output register one cycle later.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fall)
            state <= LEAD_LOW;
        end
        LEAD_LOW: begin
          if (low_cnt > CNT_W'(DATA_PERIOD)) begin
            err_q <= 1'b1;
            state <= DRAIN;
          end else if (rise) begin
            if (sym == SYM_SYNC) begin
              bit_cnt <= '0;
              state   <= HIGH;
            end else begin
              err_q <= 1'b1;
              state <= IDLE;
            end
          end
        end
        HIGH: begin
          // A falling edge coinciding with the timeout opens the next frame.
          if (hi_cnt > CNT_W'(HIGH_TIMEOUT)) begin
            err_q <= 1'b1;
            state <= fall ? LEAD_LOW : IDLE;
          end else if (fall) begin
            state <= BIT_LOW;
          end
        end
        BIT_LOW: begin
          if (low_cnt > CNT_W'(DATA_PERIOD)) begin
            err_q <= 1'b1;
            state <= DRAIN;
          end else if (rise) begin
            if (sym != SYM_SYNC) begin
              if (bit_cnt < BIT_W'(WORD_W)) begin
                shreg   <= {shreg[WORD_W-2:0], (sym == SYM_ONE)};
                bit_cnt <= bit_cnt + BIT_W'(1);
                state   <= HIGH;
              end else begin
                err_q <= 1'b1;
                state <= IDLE;
              end
            end else begin
              if (bit_cnt == BIT_W'(WORD_W))
                done_q <= 1'b1;
              else
                err_q <= 1'b1;
              state <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (line_s)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bus.data_out  <= '0;
      bus.valid_out <= 1'b0;
      bus.error_out <= 1'b0;
    end else begin
      bus.valid_out <= done_q;
      bus.error_out <= err_q;
      if (done_q)
        bus.data_out <= shreg;
    end
  end

endmodule

// File: tb/tb_diff_rx.sv
// Directed bench for diff_rx: nominal, jitter, premature SYNC, stuck-low/high and async reset.
module tb_diff_rx;
  import diff_pkg::*;

  logic clk_in;
  logic rst_n_in;

  diff_rx_if bus ();

  diff_rx dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus.slave)
  );

  int n_checks;
  int n_fail;
  int vcnt;
  int ecnt;
  logic [WORD_W-1:0] prev_data;
  logic              prev_strobe;
  logic [WORD_W-1:0] words[$];

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Strobe monitor: exclusivity, one-cycle width, data_out only moves with valid_out.
  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      prev_data   = bus.data_out;
      prev_strobe = 1'b0;
    end else begin
      if (bus.valid_out || bus.error_out) begin
        check("strobe_excl", 32'(bus.valid_out & bus.error_out), 32'd0);
        check("strobe_len", 32'(prev_strobe), 32'd0);
      end
      if (bus.valid_out) begin
        vcnt++;
        words.push_back(bus.data_out);
      end else begin
        check("data_hold", 32'(bus.data_out), 32'(prev_data));
      end
      if (bus.error_out)
        ecnt++;
      prev_strobe = bus.valid_out | bus.error_out;
      prev_data   = bus.data_out;
    end
  end

  function automatic int jit(input int i, input bit j);
    return j ? (i % 5) - 2 : 0;
  endfunction

  task automatic send_sym(input int w);
    bus.data_in = 1'b0;
    repeat (w) @(negedge clk_in);
    bus.data_in = 1'b1;
    repeat (20 - w) @(negedge clk_in);
  endtask

  // Lead SYNC plus the first n data bits, MSB first.
  task automatic send_bits(input logic [WORD_W-1:0] word, input int n, input bit j);
    send_sym(10 + jit(0, j));
    for (int i = 0; i < n; i++)
      send_sym((word[WORD_W-1-i] ? 15 : 5) + jit(i + 1, j));
  endtask

  task automatic send_frame(input logic [WORD_W-1:0] word, input bit j);
    send_bits(word, WORD_W, j);
    send_sym(10 + jit(WORD_W + 1, j));
  endtask

  // Low pulse of width w, then count negedges from the rise to the chosen strobe.
  task automatic low_and_measure(input int w, input bit want_err, output int n);
    bus.data_in = 1'b0;
    repeat (w) @(negedge clk_in);
    bus.data_in = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      n++;
      if (want_err ? bus.error_out : bus.valid_out) break;
    end
    if (20 - w - n > 0) repeat (20 - w - n) @(negedge clk_in);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, e0, n;
    n_checks = 0;
    n_fail   = 0;
    vcnt     = 0;
    ecnt     = 0;
    rst_n_in = 1'b0;
    bus.data_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check("rst_data", 32'(bus.data_out), 32'd0);
    check("rst_valid", 32'(bus.valid_out), 32'd0);
    check("rst_error", 32'(bus.error_out), 32'd0);
    rst_n_in = 1'b1;
    repeat (5) @(negedge clk_in);

    // Nominal frame with latency measurement
    v0 = vcnt; e0 = ecnt;
    send_bits(26'h2A55A5A, WORD_W, 1'b0);
    low_and_measure(10, 1'b0, n);
    check("nom_latency", 32'(n), 32'd4);
    repeat (5) @(negedge clk_in);
    check("nom_vcnt", 32'(vcnt - v0), 32'd1);
    check("nom_ecnt", 32'(ecnt - e0), 32'd0);
    check("nom_data", 32'(bus.data_out), 32'h2A55A5A);

    // Premature SYNC after 12 bits, then a clean frame
    v0 = vcnt; e0 = ecnt;
    send_bits(26'h1111111, 12, 1'b0);
    low_and_measure(10, 1'b1, n);
    check("pre_err_latency", 32'(n), 32'd4);
    repeat (5) @(negedge clk_in);
    check("pre_ecnt", 32'(ecnt - e0), 32'd1);
    check("pre_vcnt", 32'(vcnt - v0), 32'd0);
    check("pre_data_hold", 32'(bus.data_out), 32'h2A55A5A);
    send_frame(26'h1234567, 1'b0);
    repeat (5) @(negedge clk_in);
    check("post_pre_vcnt", 32'(vcnt - v0), 32'd1);
    check("post_pre_data", 32'(bus.data_out), 32'h1234567);

    // Jittered back-to-back frames
    v0 = vcnt; e0 = ecnt;
    send_frame(26'h3FFFFFF, 1'b1);
    send_frame(26'h0000000, 1'b1);
    repeat (5) @(negedge clk_in);
    check("jit_vcnt", 32'(vcnt - v0), 32'd2);
    check("jit_ecnt", 32'(ecnt - e0), 32'd0);
    if (words.size() >= 2) begin
      check("jit_word0", 32'(words[words.size()-2]), 32'h3FFFFFF);
      check("jit_word1", 32'(words[words.size()-1]), 32'h0000000);
    end else begin
      check("jit_words_seen", 32'(words.size()), 32'd2);
    end

    // Stuck low for 40 cycles mid-frame
    v0 = vcnt; e0 = ecnt;
    send_bits(26'h2AAAAAA, 5, 1'b0);
    bus.data_in = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      if (bus.error_out && n == 0) n = i + 1;
    end
    check("stuck_low_latency", 32'(n), 32'd25);
    bus.data_in = 1'b1;
    repeat (10) @(negedge clk_in);
    check("stuck_low_ecnt", 32'(ecnt - e0), 32'd1);
    check("stuck_low_vcnt", 32'(vcnt - v0), 32'd0);
    send_frame(26'h0ABCDEF, 1'b0);
    repeat (5) @(negedge clk_in);
    check("post_low_data", 32'(bus.data_out), 32'h0ABCDEF);

    // Stuck high after bit 5
    v0 = vcnt; e0 = ecnt;
    send_bits(26'h1555555, 5, 1'b0);
    bus.data_in = 1'b0;
    repeat (5) @(negedge clk_in);
    bus.data_in = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in);
      n++;
      if (bus.error_out) break;
    end
    check("stuck_high_latency", 32'(n), 32'd30);
    repeat (10) @(negedge clk_in);
    check("stuck_high_ecnt", 32'(ecnt - e0), 32'd1);
    send_frame(26'h3C0FFEE, 1'b0);
    repeat (5) @(negedge clk_in);
    check("post_high_vcnt", 32'(vcnt - v0), 32'd1);
    check("post_high_data", 32'(bus.data_out), 32'h3C0FFEE);

    // Async reset with the line low in bit 13
    send_bits(26'h2A55A5A, 13, 1'b0);
    bus.data_in = 1'b0;
    repeat (3) @(negedge clk_in);
    #2 rst_n_in = 1'b0;
    #1;
    check("arst_data", 32'(bus.data_out), 32'd0);
    check("arst_valid", 32'(bus.valid_out), 32'd0);
    check("arst_error", 32'(bus.error_out), 32'd0);
    repeat (2) @(negedge clk_in);
    bus.data_in = 1'b1;
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    v0 = vcnt; e0 = ecnt;
    repeat (40) @(negedge clk_in);
    check("arst_no_valid", 32'(vcnt - v0), 32'd0);
    check("arst_no_error", 32'(ecnt - e0), 32'd0);
    send_frame(26'h155AA55, 1'b0);
    repeat (5) @(negedge clk_in);
    check("post_arst_vcnt", 32'(vcnt - v0), 32'd1);
    check("post_arst_data", 32'(bus.data_out), 32'h155AA55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
